// File: rtl/add2bit_pkg.sv
// Shared constants and the single-bit adder helper for the add2bit slice.
package add2bit_pkg;

  localparam int ADD2BIT_WIDTH_DEFAULT = 2;
  localparam int ADD2BIT_WIDTH_MIN     = 1;
  localparam int ADD2BIT_WIDTH_MAX     = 32;

  typedef struct packed {
    logic c_out;
    logic sum;
  } fa_result_t;

  function automatic fa_result_t fa_eval(input logic a, input logic b, input logic c_in);
    fa_result_t r;
    r.sum   = a ^ b ^ c_in;
    r.c_out = (a & b) | (c_in & (a ^ b));
    return r;
  endfunction

endpackage

// File: rtl/add2bit_full_adder.sv
// One-bit full adder cell; add2bit chains WIDTH of these into a ripple-carry adder.
module full_adder_1bit
  import add2bit_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  fa_result_t res;

  always_comb begin
    res   = fa_eval(a, b, c_in);
    sum   = res.sum;
    c_out = res.c_out;
  end

endmodule

// File: rtl/add2bit.sv
// Registered WIDTH-bit ripple-carry adder with one cycle of latency.
// Optional signed-overflow output is enabled by defining ADD2BIT_OVF_EN.
module add2bit
  import add2bit_pkg::*;
#(
  parameter int WIDTH = ADD2BIT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  input  logic             in_valid,
  output logic             out_valid
`ifdef ADD2BIT_OVF_EN
  ,
  output logic             ovf
`endif
);

  generate
    if (WIDTH < ADD2BIT_WIDTH_MIN || WIDTH > ADD2BIT_WIDTH_MAX) begin : g_bad_width
      $error("add2bit: WIDTH %0d outside legal range %0d..%0d",
             WIDTH, ADD2BIT_WIDTH_MIN, ADD2BIT_WIDTH_MAX);
    end
  endgenerate

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  assign carry[0] = c_in;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      full_adder_1bit u_fa (
        .a     (a[i]),
        .b     (b[i]),
        .c_in  (carry[i]),
        .sum   (sum_comb[i]),
        .c_out (carry[i+1])
      );
    end
  endgenerate

  // Result registers hold their value while idle; only out_valid tracks in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      c_out     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= sum_comb;
        c_out <= carry[WIDTH];
      end
    end
  end

`ifdef ADD2BIT_OVF_EN
  // Signed overflow: carry into the MSB disagrees with carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= carry[WIDTH] ^ carry[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_add2bit.sv
// Self-checking bench for add2bit: WIDTH=2 and WIDTH=8 instances against an arithmetic model.
module tb_add2bit;

  localparam int W  = 2;
  localparam int W8 = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  a, b;
  logic [W8-1:0] a8, b8;
  logic          c_in, in_valid;
  logic [W-1:0]  sum;
  logic [W8-1:0] sum8;
  logic          c_out, c_out8, out_valid, out_valid8;
`ifdef ADD2BIT_OVF_EN
  logic          ovf, ovf8;
`endif

  always #5 clk = ~clk;

  add2bit #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sum       (sum),
    .c_out     (c_out),
    .in_valid  (in_valid),
    .out_valid (out_valid)
`ifdef ADD2BIT_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  add2bit #(.WIDTH(W8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a8),
    .b         (b8),
    .c_in      (c_in),
    .sum       (sum8),
    .c_out     (c_out8),
    .in_valid  (in_valid),
    .out_valid (out_valid8)
`ifdef ADD2BIT_OVF_EN
    ,
    .ovf       (ovf8)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference state: what each instance should present after the next edge.
  int exp_sum = 0, exp_cout = 0, exp_ovf = 0;
  int exp_sum8 = 0, exp_cout8 = 0, exp_ovf8 = 0;
  int exp_vld = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int to_signed(input int v, input int w);
    return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
  endfunction

  task automatic model_add(input int av, input int bv, input int cv, input int w,
                           output int s, output int co, output int ov);
    int total, ssum;
    total = av + bv + cv;
    s     = total % (1 << w);
    co    = total / (1 << w);
    ssum  = to_signed(av, w) + to_signed(bv, w) + cv;
    ov    = (ssum > (1 << (w - 1)) - 1 || ssum < -(1 << (w - 1))) ? 1 : 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".sum"},        32'(sum),        32'(exp_sum));
    check({tag, ".c_out"},      32'(c_out),      32'(exp_cout));
    check({tag, ".out_valid"},  32'(out_valid),  32'(exp_vld));
    check({tag, ".sum8"},       32'(sum8),       32'(exp_sum8));
    check({tag, ".c_out8"},     32'(c_out8),     32'(exp_cout8));
    check({tag, ".out_valid8"}, 32'(out_valid8), 32'(exp_vld));
`ifdef ADD2BIT_OVF_EN
    check({tag, ".ovf"},        32'(ovf),        32'(exp_ovf));
    check({tag, ".ovf8"},       32'(ovf8),       32'(exp_ovf8));
`endif
  endtask

  // Advance one clock: update the model from the inputs present at the edge, then check.
  task automatic tick(input string tag);
    if (!rst_n) begin
      exp_sum = 0; exp_cout = 0; exp_ovf = 0;
      exp_sum8 = 0; exp_cout8 = 0; exp_ovf8 = 0; exp_vld = 0;
    end else if (in_valid) begin
      model_add(int'(a), int'(b), int'(c_in), W, exp_sum, exp_cout, exp_ovf);
      model_add(int'(a8), int'(b8), int'(c_in), W8, exp_sum8, exp_cout8, exp_ovf8);
      exp_vld = 1;
    end else begin
      exp_vld = 0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; a = '0; b = '0; a8 = '0; b8 = '0; c_in = 1'b0; in_valid = 1'b0;
    #1;
    check_all("reset_async");
    tick("reset_hold");
    tick("reset_hold2");
    rst_n = 1'b1;

    // First capture after reset: zero operands.
    in_valid = 1'b1;
    tick("zero_add");

    // Exhaustive 2-bit sweep back-to-back, random 8-bit operands alongside.
    for (int unsigned ci = 0; ci < 2; ci++) begin
      for (int unsigned ai = 0; ai < 4; ai++) begin
        for (int unsigned bi = 0; bi < 4; bi++) begin
          a = W'(ai); b = W'(bi); c_in = ci[0];
          a8 = W8'($urandom); b8 = W8'($urandom);
          tick($sformatf("sweep_%0d_%0d_%0d", ai, bi, ci));
        end
      end
    end

    // Hold behaviour: result stays while in_valid is low.
    a = 2'd1; b = 2'd2; c_in = 1'b0; a8 = 8'd10; b8 = 8'd20;
    tick("hold_capture");
    check("hold_sum_lit", 32'(sum), 32'd3);
    in_valid = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
      a8 = W8'($urandom); b8 = W8'($urandom);
      tick($sformatf("hold_%0d", k));
    end
    check("hold_sum_lit2", 32'(sum), 32'd3);

    // 8-bit wrap into carry, and maximum-input cases.
    in_valid = 1'b1;
    a = 2'd0; b = 2'd0; c_in = 1'b0; a8 = 8'd255; b8 = 8'd1;
    tick("w8_255_1");
    check("w8_255_1_lit", {31'd0, c_out8}, 32'd1);
    a = 2'd3; b = 2'd3; c_in = 1'b1; a8 = 8'd255; b8 = 8'd255;
    tick("max_inputs");
    check("max_lit", {29'd0, c_out, sum}, 32'd7);

    // Signed-overflow cases (ovf checked only when the port exists).
    a = 2'd1; b = 2'd1; c_in = 1'b0; a8 = 8'd127; b8 = 8'd1;
    tick("ovf_1_1");
    a = 2'd2; b = 2'd2; a8 = 8'd128; b8 = 8'd128;
    tick("ovf_2_2");

    // Random traffic with random in_valid.
    for (int unsigned k = 0; k < 200; k++) begin
      a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
      a8 = W8'($urandom); b8 = W8'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      tick("random");
    end

    // Asynchronous reset mid-cycle right after a capture.
    in_valid = 1'b1; a = 2'd3; b = 2'd3; c_in = 1'b0; a8 = 8'd200; b8 = 8'd100;
    tick("pre_reset_capture");
    #3;
    rst_n = 1'b0;
    #1;
    exp_sum = 0; exp_cout = 0; exp_ovf = 0;
    exp_sum8 = 0; exp_cout8 = 0; exp_ovf8 = 0; exp_vld = 0;
    check_all("midcycle_reset");
    #2;
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick("post_release");
    tick("post_release2");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/add2bit.md
ADD2BIT -- requirements
Module: add2bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, meaning the operand width in bits; legal range is 1 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port a, input, WIDTH bits: unsigned operand A.
REQ-005 The block SHALL have port b, input, WIDTH bits: unsigned operand B.
REQ-006 The block SHALL have port c_in, input, 1 bit: carry into bit 0.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the operands and c_in are captured this cycle.
REQ-008 The block SHALL have port sum, output, WIDTH bits: the registered sum, low WIDTH bits.
REQ-009 The block SHALL have port c_out, output, 1 bit: the registered carry out of bit WIDTH-1.
REQ-010 The block SHALL have port out_valid, output, 1 bit: sum and c_out hold a new result this cycle.
REQ-011 The port order SHALL be clk, rst_n, a, b, c_in, sum, c_out, in_valid, out_valid, then ovf when ADD2BIT_OVF_EN is defined.

Function
REQ-012 {c_out, sum} SHALL equal a + b + c_in, computed at WIDTH+1 bits with no truncation.
REQ-013 The block SHALL compute the sum with a ripple-carry chain of WIDTH 1-bit full adders, bit i carry feeding bit i+1.
REQ-014 On a rising clk edge with in_valid=1, the block SHALL register sum and c_out and set out_valid=1 on the following cycle, giving a latency of exactly 1 cycle.
REQ-015 On a rising clk edge with in_valid=0, sum and c_out SHALL hold their previous values and out_valid SHALL go to 0.
REQ-016 Back-to-back in_valid=1 SHALL give one result per cycle with no bubbles, at full throughput.
REQ-017 Maximum inputs (a=b=2^WIDTH-1, c_in=1) SHALL give sum=2^WIDTH-1 and c_out=1, with no wrap beyond the carry bit.
REQ-018 The block SHALL have no combinational path from any input to any output.

Reset
REQ-019 When rst_n=0, sum, c_out and out_valid (and ovf if present) SHALL go to 0 immediately, independent of clk.
REQ-020 Reset deassertion SHALL be synchronised by the integrator; the first capture SHALL occur on the first rising clk edge with rst_n=1 and in_valid=1.
REQ-021 Reset asserted while a result is pending SHALL discard that result; out_valid SHALL NOT assert for it.

Configuration
REQ-022 When macro ADD2BIT_OVF_EN is defined, the block SHALL add output port ovf, 1 bit, registered alongside sum.
REQ-023 ovf SHALL be set when a, b and sum are read as two's-complement signed values and the signed addition overflows: the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-024 When ADD2BIT_OVF_EN is undefined, the block SHALL NOT have an ovf port and SHALL contain no overflow logic; all other behaviour SHALL be identical.

Structure
REQ-025 Package add2bit_pkg SHALL hold the constant ADD2BIT_WIDTH_DEFAULT=2 and the constant for the legal WIDTH range; add2bit SHALL use them.
REQ-026 The block SHALL contain one sub-module, full_adder_1bit, with ports a, b, c_in, sum, c_out; add2bit SHALL instantiate it WIDTH times using generate.
REQ-027 The block SHALL reject any WIDTH outside 1 to 32 at elaboration time.

Verification
REQ-028 A bench SHALL apply reset, then a=0, b=0, c_in=0 with in_valid=1; the next cycle SHALL show sum=0, c_out=0, out_valid=1.
REQ-029 A bench SHALL sweep all 16 combinations of a,b with c_in=0, then with c_in=1; each SHALL show {c_out,sum}=a+b+c_in, e.g. 2+3+0 gives sum=1, c_out=1, and 3+3+1 gives sum=3, c_out=1.
REQ-030 A bench SHALL apply a=1, b=2 with in_valid=1, then change the inputs with in_valid=0 for 3 cycles; sum SHALL stay 3, c_out 0, and out_valid SHALL be 0 after the first cycle.
REQ-031 A bench SHALL drop rst_n mid-cycle between clk edges after a=3, b=3 is captured; sum, c_out and out_valid SHALL be 0 immediately, with no result after release.
REQ-032 With ADD2BIT_OVF_EN defined, a bench SHALL apply a=1, b=1, c_in=0; the response SHALL be sum=2, c_out=0, ovf=1, and a=2, b=2 SHALL give sum=0, c_out=1, ovf=1.
REQ-033 A bench SHALL build with WIDTH=8 and apply a=255, b=1, c_in=0; the response SHALL be sum=0, c_out=1.
